// File: rtl/bp_pkg.sv
// Shared encodings and index/tag helpers for the BTB + 2-bit BHT next-PC predictor.
package bp_pkg;
   localparam int MODE_BIMODAL = 0;
   localparam int MODE_GSHARE  = 1;
   localparam logic [1:0] CNT_INIT = 2'b01;  // weakly not-taken

   function automatic logic [31:0] btb_index(input logic [31:0] pc, input int idx_w);
      return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
   endfunction

   function automatic logic [31:0] btb_tag(input logic [31:0] pc, input int idx_w);
      return pc >> (idx_w + 2);
   endfunction

   function automatic logic [31:0] bht_index(input logic [31:0] pc, input logic [31:0] ghr,
                                            input logic gshare, input int idx_w);
      return ((pc >> 2) ^ (gshare ? ghr : 32'd0)) & ((32'd1 << idx_w) - 32'd1);
   endfunction
endpackage

// File: rtl/bp_sat_counter_table.sv
// Array of 2-bit saturating counters: one combinational read, one clocked up/down write.
module bp_sat_counter_table
   import bp_pkg::*;
#(
   parameter int SETS = 4096,
   localparam int IDX_W = $clog2(SETS)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [1:0]       rd_cnt,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic             wr_up
);
   logic [1:0] cnt_q [SETS];

   assign rd_cnt = cnt_q[rd_idx];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < SETS; i++) cnt_q[i] <= CNT_INIT;
      end else if (wr_en) begin
         if (wr_up && cnt_q[wr_idx] != 2'b11)
            cnt_q[wr_idx] <= cnt_q[wr_idx] + 2'd1;
         else if (!wr_up && cnt_q[wr_idx] != 2'b00)
            cnt_q[wr_idx] <= cnt_q[wr_idx] - 2'd1;
      end
   end
endmodule

// File: rtl/npc_bp_gshare.sv
// IF-stage next-PC generator: direct-mapped BTB + 2-bit BHT (bimodal or gshare index),
// resolved non-speculatively from EX, with branch hit/total statistics.
module npc_bp_gshare
   import bp_pkg::*;
#(
   parameter int BTB_SETS = 64,
   parameter int BHT_SETS = 4096,
   parameter int GHR_W    = 8,
   parameter int MODE     = MODE_GSHARE,
   parameter int STAT_W   = 64,
   localparam int BTB_W   = $clog2(BTB_SETS),
   localparam int BHT_W   = $clog2(BHT_SETS),
   localparam int TAG_W   = 30 - BTB_W
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [31:0]       pc_if,
   output logic              pred_taken,
   output logic [31:0]       pred_target,
   output logic [BHT_W-1:0]  pred_bht_idx,
   input  logic              ex_valid,
   input  logic              ex_is_br,
   input  logic [31:0]       ex_pc,
   input  logic              ex_taken,
   input  logic [31:0]       ex_target,
   input  logic              ex_pred_taken,
   input  logic [31:0]       ex_pred_target,
   input  logic [BHT_W-1:0]  ex_bht_idx,
   input  logic              jal,
   input  logic              jalr,
   input  logic [31:0]       jal_target,
   input  logic [31:0]       jalr_target,
   input  logic              stat_clr,
   output logic [31:0]       npc,
   output logic              mispredict,
   output logic [STAT_W-1:0] br_total,
   output logic [STAT_W-1:0] br_correct
);
   logic [GHR_W-1:0] ghr;
   logic [BTB_W-1:0] btb_idx_if, btb_idx_ex;
   logic [TAG_W-1:0] tag_if, tag_ex;
   logic [1:0]       cnt_if;
   logic             btb_hit;

   logic [BTB_SETS-1:0] btb_vld;
   logic [TAG_W-1:0]    btb_tag_q [BTB_SETS];
   logic [31:0]         btb_tgt_q [BTB_SETS];

   assign btb_idx_if   = BTB_W'(btb_index(pc_if, BTB_W));
   assign btb_idx_ex   = BTB_W'(btb_index(ex_pc, BTB_W));
   assign tag_if       = TAG_W'(btb_tag(pc_if, BTB_W));
   assign tag_ex       = TAG_W'(btb_tag(ex_pc, BTB_W));
   assign pred_bht_idx = BHT_W'(bht_index(pc_if, 32'(ghr), MODE == MODE_GSHARE, BHT_W));

   bp_sat_counter_table #(.SETS(BHT_SETS)) u_bht (
      .clk    (clk),
      .rstn   (rstn),
      .rd_idx (pred_bht_idx),
      .rd_cnt (cnt_if),
      .wr_en  (ex_valid && ex_is_br),
      .wr_idx (ex_bht_idx),
      .wr_up  (ex_taken)
   );

   assign btb_hit     = btb_vld[btb_idx_if] && (btb_tag_q[btb_idx_if] == tag_if);
   assign pred_taken  = btb_hit && cnt_if[1];
   assign pred_target = btb_tgt_q[btb_idx_if];

   // A non-branch that was predicted taken is a BTB alias and must be squashed.
   assign mispredict = ex_valid && (ex_is_br
                       ? (ex_pred_taken != ex_taken || (ex_taken && ex_pred_target != ex_target))
                       : ex_pred_taken);

   always_comb begin
      npc = pc_if + 32'd4;
      if (mispredict)
         npc = (ex_is_br && ex_taken) ? ex_target : ex_pc + 32'd4;
      else if (jalr)
         npc = jalr_target;
      else if (jal)
         npc = jal_target;
      else if (pred_taken)
         npc = pred_target;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         btb_vld <= '0;
         ghr     <= '0;
      end else if (ex_valid) begin
         if (ex_is_br) begin
            ghr <= {ghr[GHR_W-2:0], ex_taken};
            if (ex_taken) btb_vld[btb_idx_ex] <= 1'b1;
         end else if (ex_pred_taken) begin
            btb_vld[btb_idx_ex] <= 1'b0;
         end
      end
   end

   // Tag/target payload is qualified by btb_vld, so it needs no reset.
   always_ff @(posedge clk) begin
      if (ex_valid && ex_is_br && ex_taken) begin
         btb_tag_q[btb_idx_ex] <= tag_ex;
         btb_tgt_q[btb_idx_ex] <= ex_target;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         br_total   <= '0;
         br_correct <= '0;
      end else if (stat_clr) begin
         br_total   <= '0;
         br_correct <= '0;
      end else if (ex_valid && ex_is_br) begin
         br_total <= br_total + STAT_W'(1);
         if (!mispredict) br_correct <= br_correct + STAT_W'(1);
      end
   end
endmodule

// File: tb/tb_npc_bp_gshare.sv
// Drives a bimodal and a gshare instance side by side and checks them against a
// table-level reference model of the predictor.
module tb_npc_bp_gshare;
   localparam int BTB = 64;
   localparam int BHT = 4096;

   typedef struct {
      logic [31:0] pc;
      bit          v, br, tk;
      logic [31:0] tgt;
      bit          j, jr;
      logic [31:0] jt, jrt;
      bit          clr;
   } stim_t;

   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] pc_if, ex_pc, ex_target, jal_target, jalr_target;
   logic        ex_valid, ex_is_br, ex_taken, jal, jalr, stat_clr;
   logic        ex_pt  [2];
   logic [31:0] ex_ptg [2];
   logic [11:0] ex_idx [2];
   logic        pred_taken  [2];
   logic [31:0] pred_target [2];
   logic [11:0] pred_idx    [2];
   logic [31:0] npc [2];
   logic        mis [2];
   logic [63:0] tot [2];
   logic [63:0] cor [2];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      npc_bp_gshare #(.BTB_SETS(BTB), .BHT_SETS(BHT), .GHR_W(8), .MODE(g), .STAT_W(64)) dut (
         .clk(clk), .rstn(rstn), .pc_if(pc_if),
         .pred_taken(pred_taken[g]), .pred_target(pred_target[g]), .pred_bht_idx(pred_idx[g]),
         .ex_valid(ex_valid), .ex_is_br(ex_is_br), .ex_pc(ex_pc), .ex_taken(ex_taken),
         .ex_target(ex_target), .ex_pred_taken(ex_pt[g]), .ex_pred_target(ex_ptg[g]),
         .ex_bht_idx(ex_idx[g]), .jal(jal), .jalr(jalr), .jal_target(jal_target),
         .jalr_target(jalr_target), .stat_clr(stat_clr), .npc(npc[g]), .mispredict(mis[g]),
         .br_total(tot[g]), .br_correct(cor[g])
      );
   end

   // Reference model: index 0 = bimodal, 1 = gshare.
   int unsigned     m_bht [2][BHT];
   bit              m_bv  [2][BTB];
   logic [31:0]     m_bpc [2][BTB];
   logic [31:0]     m_btg [2][BTB];
   int unsigned     m_ghr [2];
   longint unsigned m_tot [2];
   longint unsigned m_cor [2];

   bit          e_pt  [2];
   bit          e_mis [2];
   logic [31:0] e_ptg [2];
   logic [31:0] e_npc [2];
   int unsigned e_idx [2];
   stim_t       cur;

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < BHT; i++) m_bht[m][i] = 1;
         for (int i = 0; i < BTB; i++) m_bv[m][i] = 0;
         m_ghr[m] = 0; m_tot[m] = 0; m_cor[m] = 0;
      end
   endtask

   task automatic drive_idle();
      ex_valid = 0; ex_is_br = 0; ex_taken = 0; jal = 0; jalr = 0; stat_clr = 0;
      ex_pc = 0; ex_target = 0; jal_target = 0; jalr_target = 0;
      for (int m = 0; m < 2; m++) begin ex_pt[m] = 0; ex_ptg[m] = 0; ex_idx[m] = 0; end
   endtask

   // Predict from the model, drive one cycle (EX resolving the instruction fetched now),
   // and stop at the falling edge with expectations ready.
   task automatic apply(input stim_t s);
      int unsigned e;
      bit hit;
      cur = s;
      for (int m = 0; m < 2; m++) begin
         e_idx[m] = ((s.pc / 4) ^ (m == 1 ? m_ghr[m] : 0)) % BHT;
         e = (s.pc / 4) % BTB;
         hit = m_bv[m][e] && (m_bpc[m][e] / (4 * BTB) == s.pc / (4 * BTB));
         e_pt[m]  = hit && m_bht[m][e_idx[m]] >= 2;
         e_ptg[m] = m_btg[m][e];
         e_mis[m] = s.v && (s.br ? (e_pt[m] != s.tk || (s.tk && e_ptg[m] != s.tgt)) : e_pt[m]);
         if (e_mis[m])       e_npc[m] = (s.br && s.tk) ? s.tgt : s.pc + 32'd4;
         else if (s.jr)      e_npc[m] = s.jrt;
         else if (s.j)       e_npc[m] = s.jt;
         else if (e_pt[m])   e_npc[m] = e_ptg[m];
         else                e_npc[m] = s.pc + 32'd4;
         ex_pt[m] = e_pt[m]; ex_ptg[m] = e_ptg[m]; ex_idx[m] = 12'(e_idx[m]);
      end
      pc_if = s.pc; ex_pc = s.pc; ex_valid = s.v; ex_is_br = s.br; ex_taken = s.tk;
      ex_target = s.tgt; jal = s.j; jalr = s.jr; jal_target = s.jt; jalr_target = s.jrt;
      stat_clr = s.clr;
      @(negedge clk);
   endtask

   task automatic commit();
      int unsigned e;
      @(posedge clk);
      for (int m = 0; m < 2; m++) begin
         if (cur.clr) begin m_tot[m] = 0; m_cor[m] = 0; end
         else if (cur.v && cur.br) begin m_tot[m]++; if (!e_mis[m]) m_cor[m]++; end
         e = (cur.pc / 4) % BTB;
         if (cur.v && cur.br) begin
            if (cur.tk && m_bht[m][e_idx[m]] < 3) m_bht[m][e_idx[m]]++;
            if (!cur.tk && m_bht[m][e_idx[m]] > 0) m_bht[m][e_idx[m]]--;
            m_ghr[m] = ((m_ghr[m] << 1) | cur.tk) % 256;
            if (cur.tk) begin m_bv[m][e] = 1; m_bpc[m][e] = cur.pc; m_btg[m][e] = cur.tgt; end
         end else if (cur.v && e_pt[m]) begin
            m_bv[m][e] = 0;
         end
      end
      #1;
   endtask

   function automatic stim_t br_s(input logic [31:0] pc, input bit v, br, tk, input logic [31:0] tgt);
      stim_t s;
      s.pc = pc; s.v = v; s.br = br; s.tk = tk; s.tgt = tgt;
      s.j = 0; s.jr = 0; s.jt = 0; s.jrt = 0; s.clr = 0;
      return s;
   endfunction

   task automatic test_reset();
      rstn = 0;
      drive_idle();
      model_reset();
      apply(br_s(32'h100, 0, 0, 0, 0));
      for (int m = 0; m < 2; m++) begin
         checks++; if (npc[m] !== 32'h104) begin failures++; $display("FAIL reset_npc m%0d got=%h exp=%h", m, npc[m], 32'h104); end
         checks++; if (pred_taken[m] !== 1'b0) begin failures++; $display("FAIL reset_pred m%0d got=%b exp=0", m, pred_taken[m]); end
         checks++; if (mis[m] !== 1'b0) begin failures++; $display("FAIL reset_mis m%0d got=%b exp=0", m, mis[m]); end
         checks++; if (tot[m] !== 64'd0 || cor[m] !== 64'd0) begin failures++; $display("FAIL reset_stats m%0d got=%0d/%0d exp=0/0", m, cor[m], tot[m]); end
      end
      drive_idle();
      rstn = 1;
      @(posedge clk); #1;
   endtask

   // Bimodal spec expectations ride along with the model comparison.
   task automatic test_learn();
      stim_t rows [4];
      logic [31:0] bm_npc [4] = '{32'h180, 32'h180, 32'h204, 32'h204};
      bit bm_pt [4] = '{0, 1, 1, 0};
      bit bm_mis [4] = '{1, 0, 1, 0};
      rows[0] = br_s(32'h200, 1, 1, 1, 32'h180);
      rows[1] = br_s(32'h200, 0, 0, 0, 32'h0);
      rows[2] = br_s(32'h200, 1, 1, 0, 32'h180);
      rows[3] = br_s(32'h200, 0, 0, 0, 32'h0);
      for (int r = 0; r < 4; r++) begin
         apply(rows[r]);
         checks++; if (npc[0] !== bm_npc[r]) begin failures++; $display("FAIL learn_npc_spec r%0d got=%h exp=%h", r, npc[0], bm_npc[r]); end
         checks++; if (pred_taken[0] !== bm_pt[r]) begin failures++; $display("FAIL learn_pred_spec r%0d got=%b exp=%b", r, pred_taken[0], bm_pt[r]); end
         checks++; if (mis[0] !== bm_mis[r]) begin failures++; $display("FAIL learn_mis_spec r%0d got=%b exp=%b", r, mis[0], bm_mis[r]); end
         for (int m = 0; m < 2; m++) begin
            checks++; if (npc[m] !== e_npc[m]) begin failures++; $display("FAIL learn_npc m%0d r%0d got=%h exp=%h", m, r, npc[m], e_npc[m]); end
            checks++; if (mis[m] !== e_mis[m]) begin failures++; $display("FAIL learn_mis m%0d r%0d got=%b exp=%b", m, r, mis[m], e_mis[m]); end
         end
         commit();
      end
   endtask

   task automatic test_jumps();
      stim_t rows [4];
      logic [31:0] exp_npc [4] = '{32'h400, 32'h900, 32'h700, 32'h0};
      rows[0] = br_s(32'h300, 1, 1, 1, 32'h400);
      rows[0].j = 1; rows[0].jr = 1; rows[0].jt = 32'h700; rows[0].jrt = 32'h900;
      rows[1] = br_s(32'h340, 0, 0, 0, 32'h0);
      rows[1].j = 1; rows[1].jr = 1; rows[1].jt = 32'h700; rows[1].jrt = 32'h900;
      rows[2] = rows[1]; rows[2].jr = 0;
      rows[3] = br_s(32'hFFFF_FFFC, 0, 0, 0, 32'h0);
      for (int r = 0; r < 4; r++) begin
         apply(rows[r]);
         for (int m = 0; m < 2; m++) begin
            checks++; if (npc[m] !== exp_npc[r]) begin failures++; $display("FAIL jump_npc m%0d r%0d got=%h exp=%h", m, r, npc[m], exp_npc[r]); end
            checks++; if (mis[m] !== e_mis[m]) begin failures++; $display("FAIL jump_mis m%0d r%0d got=%b exp=%b", m, r, mis[m], e_mis[m]); end
         end
         commit();
      end
   endtask

   task automatic test_alias();
      stim_t rows [4];
      logic [31:0] bm_npc [4] = '{32'h480, 32'h480, 32'h504, 32'h504};
      bit bm_pt [4] = '{0, 1, 1, 0};
      rows[0] = br_s(32'h500, 1, 1, 1, 32'h480);
      rows[1] = br_s(32'h500, 0, 0, 0, 32'h0);
      rows[2] = br_s(32'h500, 1, 0, 0, 32'h0);
      rows[3] = br_s(32'h500, 0, 0, 0, 32'h0);
      for (int r = 0; r < 4; r++) begin
         apply(rows[r]);
         checks++; if (npc[0] !== bm_npc[r]) begin failures++; $display("FAIL alias_npc_spec r%0d got=%h exp=%h", r, npc[0], bm_npc[r]); end
         checks++; if (pred_taken[0] !== bm_pt[r]) begin failures++; $display("FAIL alias_pred_spec r%0d got=%b exp=%b", r, pred_taken[0], bm_pt[r]); end
         for (int m = 0; m < 2; m++) begin
            checks++; if (npc[m] !== e_npc[m]) begin failures++; $display("FAIL alias_npc m%0d r%0d got=%h exp=%h", m, r, npc[m], e_npc[m]); end
            checks++; if (mis[m] !== e_mis[m]) begin failures++; $display("FAIL alias_mis m%0d r%0d got=%b exp=%b", m, r, mis[m], e_mis[m]); end
         end
         commit();
      end
   endtask

   // Alternating T/N loop: gshare separates the two histories, bimodal thrashes.
   task automatic test_loop();
      stim_t s;
      for (int i = 0; i < 81; i++) begin
         s = br_s(32'h600, 1, 1, (i % 2) == 0, 32'h5F0);
         s.clr = (i == 16);
         apply(s);
         for (int m = 0; m < 2; m++) begin
            checks++; if (npc[m] !== e_npc[m] || mis[m] !== e_mis[m]) begin failures++; $display("FAIL loop_out m%0d i%0d got=%h/%b exp=%h/%b", m, i, npc[m], mis[m], e_npc[m], e_mis[m]); end
         end
         commit();
         if (i == 16) begin
            for (int m = 0; m < 2; m++) begin
               checks++; if (tot[m] !== 64'd0 || cor[m] !== 64'd0) begin failures++; $display("FAIL loop_clr m%0d got=%0d/%0d exp=0/0", m, cor[m], tot[m]); end
            end
         end
      end
      for (int m = 0; m < 2; m++) begin
         checks++; if (tot[m] !== m_tot[m] || cor[m] !== m_cor[m]) begin failures++; $display("FAIL loop_stats m%0d got=%0d/%0d exp=%0d/%0d", m, cor[m], tot[m], m_cor[m], m_tot[m]); end
      end
      checks++; if (!(tot[1] == 64'd64 && cor[1] * 10 > tot[1] * 9)) begin failures++; $display("FAIL loop_gshare_rate got=%0d/%0d exp=>0.9 of 64", cor[1], tot[1]); end
      checks++; if (!(tot[0] == 64'd64 && cor[0] * 10 < tot[0] * 6)) begin failures++; $display("FAIL loop_bimodal_rate got=%0d/%0d exp=<0.6 of 64", cor[0], tot[0]); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 4; i++) begin
         apply(br_s(32'h600, 1, 1, (i % 2) == 0, 32'h5F0));
         commit();
      end
      apply(br_s(32'h600, 1, 1, 1, 32'h5F0));
      rstn = 0;
      model_reset();
      #1;
      for (int m = 0; m < 2; m++) begin
         checks++; if (pred_taken[m] !== 1'b0) begin failures++; $display("FAIL rmid_pred m%0d got=%b exp=0", m, pred_taken[m]); end
         checks++; if (tot[m] !== 64'd0 || cor[m] !== 64'd0) begin failures++; $display("FAIL rmid_stats m%0d got=%0d/%0d exp=0/0", m, cor[m], tot[m]); end
      end
      drive_idle();
      rstn = 1;
      @(posedge clk); #1;
      apply(br_s(32'h600, 0, 0, 0, 32'h0));
      checks++; if (pred_idx[1] !== 12'h180) begin failures++; $display("FAIL rmid_ghr got=%h exp=%h", pred_idx[1], 12'h180); end
      for (int m = 0; m < 2; m++) begin
         checks++; if (pred_taken[m] !== 1'b0 || npc[m] !== 32'h604) begin failures++; $display("FAIL rmid_lookup m%0d got=%b/%h exp=0/%h", m, pred_taken[m], npc[m], 32'h604); end
      end
      commit();
   endtask

   task automatic test_random();
      stim_t s;
      logic [31:0] tgts [3] = '{32'h2000, 32'h2040, 32'h3000};
      for (int i = 0; i < 400; i++) begin
         s.pc  = 32'h1000 + 32'(4 * $urandom_range(0, 7)) + 32'(256 * $urandom_range(0, 1));
         s.v   = ($urandom % 8) != 0;
         s.br  = ($urandom % 4) != 0;
         s.tk  = $urandom % 2;
         s.tgt = tgts[$urandom_range(0, 2)];
         s.j   = ($urandom % 8) == 0;
         s.jr  = ($urandom % 8) == 0;
         s.jt  = $urandom & 32'hFFFF_FFFC;
         s.jrt = $urandom & 32'hFFFF_FFFC;
         s.clr = ($urandom % 50) == 0;
         apply(s);
         for (int m = 0; m < 2; m++) begin
            checks++; if (npc[m] !== e_npc[m]) begin failures++; $display("FAIL rnd_npc m%0d i%0d got=%h exp=%h", m, i, npc[m], e_npc[m]); end
            checks++; if (mis[m] !== e_mis[m]) begin failures++; $display("FAIL rnd_mis m%0d i%0d got=%b exp=%b", m, i, mis[m], e_mis[m]); end
            checks++; if (pred_taken[m] !== e_pt[m]) begin failures++; $display("FAIL rnd_pred m%0d i%0d got=%b exp=%b", m, i, pred_taken[m], e_pt[m]); end
            checks++; if (pred_idx[m] !== 12'(e_idx[m])) begin failures++; $display("FAIL rnd_idx m%0d i%0d got=%h exp=%h", m, i, pred_idx[m], 12'(e_idx[m])); end
            if (e_pt[m]) begin
               checks++; if (pred_target[m] !== e_ptg[m]) begin failures++; $display("FAIL rnd_tgt m%0d i%0d got=%h exp=%h", m, i, pred_target[m], e_ptg[m]); end
            end
            checks++; if (tot[m] !== m_tot[m] || cor[m] !== m_cor[m]) begin failures++; $display("FAIL rnd_stats m%0d i%0d got=%0d/%0d exp=%0d/%0d", m, i, cor[m], tot[m], m_cor[m], m_tot[m]); end
         end
         commit();
      end
   endtask

   initial begin
      pc_if = 0;
      test_reset();
      test_learn();
      test_jumps();
      test_alias();
      test_loop();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
